// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - binary32 field layout and constants shared by the FPU units
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Exponent 0 covers true zero and subnormals, which are flushed to zero.
    function automatic logic fp_is_zero(input fp32_t f);
        return f.exp == '0;
    endfunction

endpackage

// File: rtl/fdiv_mant.sv
// rtl/fdiv_mant.sv - combinational restoring divider for 24-bit mantissas
module fdiv_mant (
    input  logic [23:0] i_mx1,
    input  logic [23:0] i_mx2,
    output logic [22:0] o_frac,
    output logic        o_guard,
    output logic        o_round,
    output logic        o_sticky,
    output logic        o_norm
);

    logic [24:0] w_rem;
    logic [26:0] w_q;

    // 27 quotient bits of mx1/mx2: one spare bit absorbs the mx1 < mx2 case.
    always_comb begin
        w_rem = {1'b0, i_mx1};
        w_q   = '0;
        for (int i = 26; i >= 0; i--) begin
            if (w_rem >= {1'b0, i_mx2}) begin
                w_q[i] = 1'b1;
                w_rem  = w_rem - {1'b0, i_mx2};
            end
            w_rem = w_rem << 1;
        end
    end

    always_comb begin
        o_norm = ~w_q[26];
        if (w_q[26]) begin
            o_frac   = w_q[25:3];
            o_guard  = w_q[2];
            o_round  = w_q[1];
            o_sticky = w_q[0] | (|w_rem);
        end else begin
            o_frac   = w_q[24:2];
            o_guard  = w_q[1];
            o_round  = w_q[0];
            o_sticky = |w_rem;
        end
    end

endmodule

// File: rtl/fdiv_unit.sv
// rtl/fdiv_unit.sv - binary32 divider, one-cycle latency; FDIV_NAN_INF_EN enables inf/NaN decode
module fdiv_unit
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);

    fp32_t              w_a;
    fp32_t              w_b;
    logic               w_sign;
    logic               w_z1;
    logic               w_z2;
    logic [22:0]        w_frac;
    logic               w_guard;
    logic               w_round;
    logic               w_sticky;
    logic               w_norm;
    logic               w_round_up;
    logic signed [9:0]  w_exp_pre;
    logic [32:0]        w_sum;
    logic signed [9:0]  w_exp_fin;
    logic [31:0]        w_res;
    logic [31:0]        r_y;

    assign w_a    = x1;
    assign w_b    = x2;
    assign w_sign = w_a.sign ^ w_b.sign;
    assign w_z1   = fp_is_zero(w_a);
    assign w_z2   = fp_is_zero(w_b);

    fdiv_mant u_mant (
        .i_mx1   ({1'b1, w_a.frac}),
        .i_mx2   ({1'b1, w_b.frac}),
        .o_frac  (w_frac),
        .o_guard (w_guard),
        .o_round (w_round),
        .o_sticky(w_sticky),
        .o_norm  (w_norm)
    );

    assign w_exp_pre  = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                      + 10'(BIAS) - $signed({9'd0, w_norm});
    assign w_round_up = w_guard & (w_round | w_sticky | w_frac[0]);

    // Rounding over {exp, frac} lets a mantissa carry ripple straight into the exponent.
    assign w_sum     = {w_exp_pre, w_frac} + {32'd0, w_round_up};
    assign w_exp_fin = $signed(w_sum[32:23]);

    always_comb begin
        if (w_exp_fin >= 10'sd255)
            w_res = {w_sign, POS_INF[30:0]};
        else if (w_exp_fin <= 10'sd0)
            w_res = {w_sign, 31'd0};
        else
            w_res = {w_sign, w_exp_fin[7:0], w_sum[22:0]};

`ifdef FDIV_NAN_INF_EN
        if ((w_a.exp == 8'hFF && w_a.frac != '0) || (w_b.exp == 8'hFF && w_b.frac != '0))
            w_res = QNAN;
        else if (w_a.exp == 8'hFF && w_b.exp == 8'hFF)
            w_res = QNAN;
        else if (w_z1 && w_z2)
            w_res = QNAN;
        else if (w_a.exp == 8'hFF)
            w_res = {w_sign, POS_INF[30:0]};
        else if (w_b.exp == 8'hFF)
            w_res = {w_sign, 31'd0};
        else if (w_z2)
            w_res = {w_sign, POS_INF[30:0]};
        else if (w_z1)
            w_res = {w_sign, 31'd0};
`else
        if (w_z1 && w_z2)
            w_res = {w_sign, 31'd0};
        else if (w_z2)
            w_res = {w_sign, POS_INF[30:0]};
        else if (w_z1)
            w_res = {w_sign, 31'd0};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_y <= '0;
        else
            r_y <= w_res;
    end

    assign y = r_y;

endmodule

// File: tb/tb_fdiv_unit.sv
// tb/tb_fdiv_unit.sv - scoreboard bench for fdiv_unit: directed vectors plus random normals against a real-valued reference
module tb_fdiv_unit;

    logic        clk;
    logic        rst;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];
    string       name_q[$];

    fdiv_unit dut (
        .clk(clk),
        .rst(rst),
        .x1 (x1),
        .x2 (x2),
        .y  (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for normal operands: exact double quotient, then round-to-nearest-even to 24 bits.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        real         ra;
        real         rb;
        logic [63:0] d;
        logic [24:0] keep;
        logic [28:0] low;
        int          e;
        ra = $bitstoreal({a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0});
        rb = $bitstoreal({b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0});
        d    = $realtobits(ra / rb);
        keep = {2'b01, d[51:29]};
        low  = d[28:0];
        if (low > 29'h10000000 || (low == 29'h10000000 && keep[0]))
            keep = keep + 25'd1;
        e = int'(d[62:52]) - 1023 + 127;
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        return {d[63], e[7:0], keep[22:0]};
    endfunction

    task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string nm);
        @(negedge clk);
        rst = r;
        x1  = a;
        x2  = b;
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] want;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = y;
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s: y=%08h expected %08h", nm, got, want);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        x1  = '0;
        x2  = '0;

        issue(1'b1, 32'h40000000, 32'h3F800000, 32'h00000000, "reset_hold0");
        issue(1'b1, 32'h40000000, 32'h3F800000, 32'h00000000, "reset_hold1");
        issue(1'b0, 32'h40000000, 32'h3F800000, 32'h40000000, "first_after_reset");

        issue(1'b0, 32'h3F800000, 32'h40000000, 32'h3F000000, "one_div_two");
        issue(1'b0, 32'hBF800000, 32'h40000000, 32'hBF000000, "neg_one_div_two");
        issue(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "one_div_three");
        issue(1'b0, 32'h40C00000, 32'h40400000, 32'h40000000, "six_div_three");
        issue(1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, "div_by_zero");
        issue(1'b0, 32'h3F800000, 32'h80000000, 32'hFF800000, "div_by_neg_zero");
`ifdef FDIV_NAN_INF_EN
        issue(1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, "zero_div_zero");
        issue(1'b0, 32'h7F800000, 32'h40000000, 32'h7F800000, "exp255_dividend");
`else
        issue(1'b0, 32'h00000000, 32'h00000000, 32'h00000000, "zero_div_zero");
        issue(1'b0, 32'h7F800000, 32'h40000000, 32'h7F000000, "exp255_dividend");
`endif
        issue(1'b0, 32'h80000000, 32'h40000000, 32'h80000000, "neg_zero_dividend");
        issue(1'b0, 32'h00800000, 32'h40000000, 32'h00000000, "underflow");
        issue(1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, "overflow");
        issue(1'b0, 32'h000FFFFF, 32'hBF800000, 32'h80000000, "subnormal_flush");
        issue(1'b0, 32'h40000000, 32'h7F800000, 32'h00000000, "div_by_exp255");
        issue(1'b0, 32'h3FFFFFFF, 32'h3F800001, 32'h3FFFFFFD, "max_mant_div");

        issue(1'b1, 32'h40400000, 32'h3F800000, 32'h00000000, "midstream_reset");
        issue(1'b0, 32'h40400000, 32'h3F800000, 32'h40400000, "after_midstream_reset");

        for (int i = 0; i < 2000; i++) begin
            a = {1'($urandom), 8'($urandom_range(70, 180)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(70, 180)), 23'($urandom)};
            issue(1'b0, a, b, ref_div(a, b), "random");
        end

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
